// File: rtl/key_event_decoder.sv
// Classifies a debounced key level into press/release edges and short, long and
// double-click events, with a wrapping click counter and two LED toggles.
module key_event_decoder #(
   parameter int unsigned LONG_TIME  = 50000000,
   parameter int unsigned DOUBLE_GAP = 15000000,
   parameter int unsigned CNT_W      = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_in,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       short_press,
   output logic       long_press,
   output logic       double_click,
   output logic [7:0] click_cnt,
   output logic       led_short,
   output logic       led_long
);

   localparam logic [2:0] S_IDLE           = 3'd0;
   localparam logic [2:0] S_PRESSED        = 3'd1;
   localparam logic [2:0] S_LONG_HELD      = 3'd2;
   localparam logic [2:0] S_WAIT_SECOND    = 3'd3;
   localparam logic [2:0] S_SECOND_PRESSED = 3'd4;

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TIME - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP - 1);
   localparam logic [CNT_W-1:0] TIMER_MAX = '1;

   // Elaboration guard: both terminal counts must be representable in the timer.
   if ((((LONG_TIME - 1) >> CNT_W) != 0) || (((DOUBLE_GAP - 1) >> CNT_W) != 0)) begin : g_cnt_w_too_narrow
      $error("key_event_decoder: CNT_W too narrow for LONG_TIME-1 / DOUBLE_GAP-1");
   end

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             key_d_q;
   logic             armed_q, armed_d;
   logic             press_q, release_q;
   logic             short_q, short_d;
   logic             long_q, long_d;
   logic             double_q, double_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             led_short_q, led_short_d;
   logic             led_long_q, led_long_d;
   logic             rise, fall;

   // Edges only count once the key has been seen released after reset.
   assign rise    = armed_q & key_in & ~key_d_q;
   assign fall    = armed_q & ~key_in & key_d_q;
   assign armed_d = armed_q | ~key_in;

   // Next-state, event and timer logic.
   always_comb begin
      state_d  = state_q;
      short_d  = 1'b0;
      long_d   = 1'b0;
      double_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rise) state_d = S_PRESSED;
         end
         S_PRESSED: begin
            if (key_in && (timer_q == LONG_LAST)) begin
               long_d  = 1'b1;
               state_d = S_LONG_HELD;
            end else if (fall) begin
               state_d = S_WAIT_SECOND;
            end
         end
         S_LONG_HELD: begin
            if (fall) state_d = S_IDLE;
         end
         S_WAIT_SECOND: begin
            // A rise on the final gap cycle still counts as the second click.
            if (rise) begin
               state_d = S_SECOND_PRESSED;
            end else if (timer_q == GAP_LAST) begin
               short_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_SECOND_PRESSED: begin
            if (fall) begin
               double_d = 1'b1;
               state_d  = S_IDLE;
            end else if (key_in && (timer_q == LONG_LAST)) begin
               long_d  = 1'b1;
               state_d = S_LONG_HELD;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q) begin
         timer_d = '0;
      end else if (timer_q == TIMER_MAX) begin
         timer_d = timer_q;
      end else begin
         timer_d = timer_q + CNT_W'(1);
      end

      cnt_d       = cnt_q + 8'(short_d | double_d);
      led_short_d = led_short_q ^ short_d;
      led_long_d  = led_long_q ^ long_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         key_d_q     <= 1'b1;
         armed_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         short_q     <= 1'b0;
         long_q      <= 1'b0;
         double_q    <= 1'b0;
         cnt_q       <= 8'd0;
         led_short_q <= 1'b0;
         led_long_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         key_d_q     <= key_in;
         armed_q     <= armed_d;
         press_q     <= rise;
         release_q   <= fall;
         short_q     <= short_d;
         long_q      <= long_d;
         double_q    <= double_d;
         cnt_q       <= cnt_d;
         led_short_q <= led_short_d;
         led_long_q  <= led_long_d;
      end
   end

   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign short_press   = short_q;
   assign long_press    = long_q;
   assign double_click  = double_q;
   assign click_cnt     = cnt_q;
   assign led_short     = led_short_q;
   assign led_long      = led_long_q;

endmodule
